// File: rtl/game_pkg.sv
// Shared types and constants for the mode counter.
// Build option: define GAME_SAT_EN to make the counter saturate instead of wrap.
package game_pkg;

    localparam int unsigned GAME_WIDTH = 4;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/mode_counter_flags_counter_step.sv
// Combinational step unit: next count from current count and mode, plus
// boundary hits on the new value.
// Build option: GAME_SAT_EN selects clamping at 0 / all-ones instead of wrap.
module counter_step
    import game_pkg::*;
#(
    parameter int unsigned WIDTH = GAME_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             win_o,
    output logic             lose_o
);

    mode_e            mode_s;
    logic [WIDTH-1:0] step_s;
    logic             up_s;
`ifdef GAME_SAT_EN
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
`endif

    // Decode the mode into a magnitude and direction, then add or subtract.
    always_comb begin
        mode_s = mode_e'(mode_i);
        up_s   = (mode_s == UP1) || (mode_s == UP2);
        step_s = ((mode_s == UP2) || (mode_s == DN2)) ? WIDTH'(2) : WIDTH'(1);
`ifdef GAME_SAT_EN
        // The extra top bit flags overflow (up) or borrow (down) for clamping.
        sum_s  = {1'b0, count_i} + {1'b0, step_s};
        diff_s = {1'b0, count_i} - {1'b0, step_s};
        if (up_s) begin
            next_o = sum_s[WIDTH] ? '1 : sum_s[WIDTH-1:0];
        end else begin
            next_o = diff_s[WIDTH] ? '0 : diff_s[WIDTH-1:0];
        end
`else
        next_o = up_s ? (count_i + step_s) : (count_i - step_s);
`endif
        win_o  = (next_o == '1);
        lose_o = (next_o == '0);
    end

endmodule

// File: rtl/mode_counter_flags.sv
// Multimode game counter: loads a start value, steps by +/-1 or +/-2 each
// cycle, pulses win/lose flags when a step lands on all-ones/zero, and
// freezes while gameover is high.
// Build option: GAME_SAT_EN (saturating arithmetic, handled in counter_step).
module mode_counter_flags
    import game_pkg::*;
#(
    parameter int unsigned WIDTH = GAME_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             init,
    input  logic [WIDTH-1:0] init_value,
    input  logic             gameover,
    output logic [WIDTH-1:0] count,
    output logic             winner_flag,
    output logic             loser_flag
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    logic [WIDTH-1:0] step_next;
    logic             step_win;
    logic             step_lose;

    counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .count_i (count_q),
        .mode_i  (mode),
        .next_o  (step_next),
        .win_o   (step_win),
        .lose_o  (step_lose)
    );

    // State, count and flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Next state: gameover beats init beats step; flags only on a real step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        if (gameover) begin
            if (state_q == RUN) begin
                state_d = HALT;
            end
        end else if (init) begin
            state_d = RUN;
            count_d = init_value;
        end else if (state_q == RUN) begin
            count_d = step_next;
            win_d   = step_win;
            lose_d  = step_lose;
        end
    end

    assign count       = count_q;
    assign winner_flag = win_q;
    assign loser_flag  = lose_q;

endmodule

// File: tb/tb_mode_counter_flags.sv
// Self-checking bench for mode_counter_flags (WIDTH=4): directed vector
// table, hand-written multi-cycle sequences, and randomized traffic checked
// against an arithmetic reference model.
module tb_mode_counter_flags;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic         init;
    logic [W-1:0] init_value;
    logic         gameover;
    logic [W-1:0] count;
    logic         winner_flag;
    logic         loser_flag;

    int checks;
    int errors;

    mode_counter_flags #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .init        (init),
        .init_value  (init_value),
        .gameover    (gameover),
        .count       (count),
        .winner_flag (winner_flag),
        .loser_flag  (loser_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         init;
        logic [W-1:0] val;
        logic [1:0]   mode;
        logic         go;
        logic [W-1:0] ecount;
        logic         ewin;
        logic         elose;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int  m_cnt;
    bit  m_active;
    bit  m_frozen;
    bit  m_win;
    bit  m_lose;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int ec, input int ew, input int el);
        check({name, ".count"}, int'(count), ec);
        check({name, ".win"}, int'(winner_flag), ew);
        check({name, ".lose"}, int'(loser_flag), el);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i, input logic [W-1:0] v, input logic [1:0] m, input logic g);
        init       = i;
        init_value = v;
        mode       = m;
        gameover   = g;
    endtask

    function automatic void add(input logic i, input logic [W-1:0] v, input logic [1:0] m,
                                input logic g, input logic [W-1:0] ec, input logic ew,
                                input logic el);
        vec_t r;
        r.init = i; r.val = v; r.mode = m; r.go = g;
        r.ecount = ec; r.ewin = ew; r.elose = el;
        tbl.push_back(r);
    endfunction

    // Model: one clock edge with the currently driven inputs.
    task automatic model_edge();
        int v;
        int delta;
        m_win  = 0;
        m_lose = 0;
        if (rst) begin
            m_cnt = 0; m_active = 0; m_frozen = 0;
        end else if (gameover) begin
            if (m_active) m_frozen = 1;
        end else if (init) begin
            m_cnt = int'(init_value); m_active = 1; m_frozen = 0;
        end else if (m_active && !m_frozen) begin
            case (mode)
                2'd0: delta = 1;
                2'd1: delta = 2;
                2'd2: delta = -1;
                default: delta = -2;
            endcase
            v = m_cnt + delta;
`ifdef GAME_SAT_EN
            if (v > MAX) v = MAX;
            if (v < 0) v = 0;
`else
            v = ((v % (MAX + 1)) + (MAX + 1)) % (MAX + 1);
`endif
            m_cnt  = v;
            m_win  = (v == MAX);
            m_lose = (v == 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0);
        #2;

        // Reset: outputs cleared immediately and while held
        rst = 1'b1;
        #1;
        check_out("reset_async", 0, 0, 0);
        tick();
        check_out("reset_held", 0, 0, 0);
        rst = 1'b0;
        tick();
        check_out("idle_wait", 0, 0, 0);

        // Directed vector table
        add(1, 4'hD, 2'd0, 0, 4'hD, 0, 0);
        add(0, 4'h0, 2'd0, 0, 4'hE, 0, 0);
        add(0, 4'h0, 2'd0, 0, 4'hF, 1, 0);
`ifdef GAME_SAT_EN
        add(0, 4'h0, 2'd0, 0, 4'hF, 1, 0);
        add(0, 4'h0, 2'd0, 0, 4'hF, 1, 0);
`else
        add(0, 4'h0, 2'd0, 0, 4'h0, 0, 1);
        add(0, 4'h0, 2'd0, 0, 4'h1, 0, 0);
`endif
        add(1, 4'h3, 2'd3, 0, 4'h3, 0, 0);
`ifdef GAME_SAT_EN
        add(0, 4'h0, 2'd3, 0, 4'h1, 0, 0);
        add(0, 4'h0, 2'd3, 0, 4'h0, 0, 1);
        add(0, 4'h0, 2'd3, 0, 4'h0, 0, 1);
`else
        add(0, 4'h0, 2'd3, 0, 4'h1, 0, 0);
        add(0, 4'h0, 2'd3, 0, 4'hF, 1, 0);
        add(0, 4'h0, 2'd3, 0, 4'hD, 0, 0);
`endif
        add(1, 4'hF, 2'd2, 0, 4'hF, 0, 0);
        add(0, 4'h0, 2'd2, 0, 4'hE, 0, 0);
        add(1, 4'h0, 2'd0, 0, 4'h0, 0, 0);
        add(0, 4'h0, 2'd0, 0, 4'h1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].init, tbl[i].val, tbl[i].mode, tbl[i].go);
            tick();
            check_out($sformatf("vec%0d", i), int'(tbl[i].ecount),
                      int'(tbl[i].ewin), int'(tbl[i].elose));
        end

        // Gameover freeze; init in the same cycle is ignored
        drive(1, 4'h5, 2'd1, 0); tick(); check_out("go_load", 5, 0, 0);
        drive(0, 4'h0, 2'd1, 0); tick(); check_out("go_step", 7, 0, 0);
        drive(1, 4'h2, 2'd1, 1); tick(); check_out("go_with_init", 7, 0, 0);
        drive(0, 4'h0, 2'd1, 1);
        for (int i = 0; i < 9; i++) begin
            tick(); check_out($sformatf("go_hold%0d", i), 7, 0, 0);
        end
        drive(0, 4'h0, 2'd1, 0); tick(); check_out("halt_hold", 7, 0, 0);
        drive(1, 4'h2, 2'd1, 0); tick(); check_out("halt_reload", 2, 0, 0);
        drive(0, 4'h0, 2'd1, 0); tick(); check_out("halt_resume", 4, 0, 0);

        // Asynchronous reset between edges
        drive(1, 4'h7, 2'd0, 0); tick();
        drive(0, 4'h0, 2'd0, 0); tick(); tick();
        check_out("pre_rst", 9, 0, 0);
        #2 rst = 1'b1;
        #1 check_out("mid_rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        tick(); check_out("post_rst_idle0", 0, 0, 0);
        tick(); check_out("post_rst_idle1", 0, 0, 0);

        // Saturation (or wrap) from E in mode +2
        drive(1, 4'hE, 2'd1, 0); tick(); check_out("sat_load", 14, 0, 0);
        drive(0, 4'h0, 2'd1, 0);
`ifdef GAME_SAT_EN
        for (int i = 0; i < 3; i++) begin
            tick(); check_out($sformatf("sat%0d", i), 15, 1, 0);
        end
`else
        tick(); check_out("wrap0", 0, 0, 1);
        tick(); check_out("wrap1", 2, 0, 0);
        tick(); check_out("wrap2", 4, 0, 0);
`endif

        // Randomized traffic against the reference model
        rst = 1'b1;
        drive(0, 4'h0, 2'd0, 0);
        tick();
        model_edge();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            init       = ($urandom_range(0, 5) == 0);
            gameover   = ($urandom_range(0, 9) == 0);
            mode       = 2'($urandom_range(0, 3));
            init_value = W'($urandom_range(0, MAX));
            tick();
            model_edge();
            check_out($sformatf("rnd%0d", i), m_cnt, int'(m_win), int'(m_lose));
            check("rnd_excl", int'(winner_flag && loser_flag), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_counter_flags.md
# mode_counter_flags

Multimode game counter that produces the `winner_flag`/`loser_flag` pulses consumed by `game_state`. It loads a start value and steps up or down by 1 or 2 each cycle according to `mode`. It pulses a flag whenever a counting step lands on all-ones (win) or all-zeros (lose). It freezes when `game_state` raises `gameover`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mode`  in  2  step select: 00 = +1, 01 = +2, 10 = −1, 11 = −2.
- `init`  in  1  load request.
- `init_value`  in  WIDTH  value loaded on `init`.
- `gameover`  in  1  from `game_state`; halts counting.
- `count`  out  WIDTH  current counter value.
- `winner_flag`  out  1  one-cycle pulse: a step produced all-ones.
- `loser_flag`  out  1  one-cycle pulse: a step produced zero.

## Operation
- States:
  - IDLE: after reset; `count` holds; no flags.
  - RUN: steps every cycle.
  - HALT: `count` frozen; no flags.
- Transitions:
  - IDLE --`init`--> RUN, loading `init_value`.
  - RUN --`gameover`--> HALT.
  - RUN --`init`--> RUN, reloading `init_value`.
  - HALT --`init` with `gameover` low--> RUN, reloading.
  - Otherwise the state holds.
- Priority: `rst` > `gameover` > `init` > step.
  - `gameover` and `init` in the same cycle: `gameover` wins; no load.
- Step arithmetic: modulo 2^WIDTH; wrap-around is the default behaviour.
  - 4'hF +1 → 0.
  - 4'h1 −2 → 4'hF.
- Flags are computed from the new count value of a counting step only:
  - `winner_flag` = (new count == all-ones).
  - `loser_flag` = (new count == 0).
  - A load never raises a flag, even if `init_value` is 0 or all-ones.
  - The two flags are never high together.
- ±2 steps can skip a boundary. No flag is raised for a skipped value.
- `mode` is sampled every cycle; a change takes effect on the next step.

## Timing
- Reset values: state IDLE, `count` = 0, `winner_flag` = 0, `loser_flag` = 0.
- `init` sampled high at edge n: `count` = `init_value` after edge n. First step at edge n+1.
- Flags are registered and change on the same edge as `count`. A flag is high exactly in the cycle where `count` shows the boundary value produced by that step.
- `gameover` sampled high at edge n:
  - `count` holds its pre-edge value.
  - Both flags are 0 after edge n.
- `rst` asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- On `rst` release, the block waits in IDLE for `init`.

## Configuration
- `GAME_SAT_EN` defined: the counter saturates instead of wrapping.
  - An up step from ≥ max−step+1 clamps to all-ones.
  - A down step below 0 clamps to 0.
  - Every step that yields a boundary value pulses its flag, including repeated steps while clamped. `winner_flag` therefore stays high every cycle while counting up at max.
- Undefined: modulo wrap as described under Operation.

## Structure
- Package `game_pkg`:
  - `mode_e` enum (`UP1`, `UP2`, `DN1`, `DN2`).
  - `cnt_state_e` enum (`IDLE`, `RUN`, `HALT`).
  - `GAME_WIDTH` constant, default 4.
- Sub-module `counter_step`: purely combinational.
  - Inputs: current count, mode.
  - Outputs: next count, win hit, lose hit.
  - Holds the wrap/saturate logic under `GAME_SAT_EN`.
- Top-level holds the FSM, the count register and the flag registers.

## Test plan
All scenarios use WIDTH=4.

1. Reset, then load. Pulse `rst`, then hold `init` for one cycle with `init_value` = 4'hD, mode 00.
   - Required: outputs 0 during reset; `count` = D, E, F, 0.
   - `winner_flag` high only in the F cycle; `loser_flag` high only in the 0 cycle.
2. Wrap and skip, mode 11 from 4'h3.
   - Required: `count` = 1, F, D.
   - `winner_flag` high in the F cycle; no `loser_flag`, because 0 was skipped.
3. Gameover. Assert `gameover` while `count` = 7 in mode 01.
   - Required: `count` stays 7 and flags stay 0 for 10 cycles.
   - An `init` issued during the same cycle as `gameover` is ignored.
   - Drop `gameover`, then pulse `init` with 4'h2: `count` = 2, then 4.
4. Load of a boundary value. `init` with 4'hF in mode 10.
   - Required: no flag on the load; `count` = E next.
5. Asynchronous reset mid-run. Assert `rst` between clock edges while `count` = 9.
   - Required: `count` = 0 and flags = 0 before the next edge; state is IDLE after release.
6. Saturation, `GAME_SAT_EN` build. Mode 01 from 4'hE.
   - Required: `count` = F, F, F.
   - `winner_flag` high for all three cycles.
